// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with burst lock.
// Define RAM_ARB_STATS_EN to add per-requester saturating grant counters (stat_gnt_cnt, stat_clr).
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          hold,
    output logic                          rvalid,
    output logic [ID_WIDTH-1:0]           rid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout
`ifdef RAM_ARB_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [NUM_REQ*16-1:0]         stat_gnt_cnt
`endif
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                state_reg, state_next;
    logic [ID_WIDTH-1:0]   rr_reg, rr_next;
    logic [ID_WIDTH-1:0]   owner_reg, owner_next;
    logic [7:0]            count_reg, count_next;
    logic [ID_WIDTH-1:0]   winner, winner_inc, owner_inc, xfer_id;
    logic [NUM_REQ-1:0]    req_rot;
    logic                  found, xfer;
    logic [ID_WIDTH-1:0]   cmd_id_reg, rd_id_reg;
    logic                  rd_pend_reg;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] din_arr  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign din_arr[gi]  = req_din[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Rotate so bit 0 is the requester at the rr pointer; first set bit wins.
    assign req_rot = NUM_REQ'({req, req} >> rr_reg);

    always_comb begin
        int sum;
        found  = 1'b0;
        winner = '0;
        sum    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found  = 1'b1;
                sum    = int'(rr_reg) + k;
                if (sum >= NUM_REQ) sum = sum - NUM_REQ;
                winner = ID_WIDTH'(sum);
            end
        end
    end

    assign winner_inc = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign owner_inc  = (owner_reg == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
    assign xfer_id    = (state_reg == LOCK) ? owner_reg : winner;
    assign xfer       = |gnt;

    always_comb begin
        gnt        = '0;
        state_next = state_reg;
        rr_next    = rr_reg;
        owner_next = owner_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (found && !hold) begin
                    gnt[winner] = 1'b1;
                    owner_next  = winner;
                    count_next  = 8'd1;
                    if (BURST_LEN > 1) state_next = LOCK;
                    else               rr_next    = winner_inc;
                end
            end
            LOCK: begin
                if (req[owner_reg] && !hold) begin
                    gnt[owner_reg] = 1'b1;
                    count_next     = count_reg + 8'd1;
                    if (count_reg == 8'(BURST_LEN - 1)) begin
                        rr_next    = owner_inc;
                        state_next = IDLE;
                    end
                end else begin
                    // Owner released or hold: give up the lock with no grant this cycle.
                    rr_next    = owner_inc;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) gnt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rr_reg      <= '0;
            owner_reg   <= '0;
            count_reg   <= '0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= '0;
            cmd_id_reg  <= '0;
            rd_pend_reg <= 1'b0;
            rd_id_reg   <= '0;
            rvalid      <= 1'b0;
            rid         <= '0;
            rdata       <= '0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            owner_reg <= owner_next;
            count_reg <= count_next;
            if (xfer) begin
                ram_en     <= 1'b1;
                ram_we     <= req_we[xfer_id];
                ram_addr   <= addr_arr[xfer_id];
                ram_din    <= din_arr[xfer_id];
                cmd_id_reg <= xfer_id;
            end else begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
            end
            // RAM read data is valid the cycle after the command; capture it then.
            rd_pend_reg <= ram_en & ~ram_we;
            rd_id_reg   <= cmd_id_reg;
            rvalid      <= rd_pend_reg;
            if (rd_pend_reg) begin
                rid   <= rd_id_reg;
                rdata <= ram_dout;
            end
        end
    end

    assign busy = ram_en | rd_pend_reg;

`ifdef RAM_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                                    cnt_reg <= '0;
                else if (stat_clr)                          cnt_reg <= '0;
                else if (gnt[gi] && cnt_reg != 16'hFFFF)    cnt_reg <= cnt_reg + 16'd1;
            end
            assign stat_gnt_cnt[gi*16 +: 16] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed scenarios plus randomized traffic against a grant-order model.
module tb_ram_port_arbiter;
    localparam int DW = 8, AW = 4, N = 4, IW = 2, BL = 4;

    logic            clk = 1'b0, rst = 1'b1, hold = 1'b0;
    logic [N-1:0]    req = '0, req_we = '0, gnt;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_din = '0;
    logic            rvalid, busy, ram_en, ram_we;
    logic [IW-1:0]   rid;
    logic [DW-1:0]   rdata, ram_din, ram_dout;
    logic [AW-1:0]   ram_addr;
`ifdef RAM_ARB_STATS_EN
    logic            stat_clr = 1'b0;
    logic [N*16-1:0] stat_gnt_cnt;
`endif

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N), .ID_WIDTH(IW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
        .gnt(gnt), .hold(hold), .rvalid(rvalid), .rid(rid), .rdata(rdata), .busy(busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef RAM_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_gnt_cnt(stat_gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM standing in for the shared port.
    logic [DW-1:0] ram_mem [1<<AW];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            else        ram_dout <= ram_mem[ram_addr];
        end
    end

    // Reference model: arbitration rules, memory image, expected read returns.
    typedef struct { int due; logic [IW-1:0] id; logic [DW-1:0] data; } rd_t;
    rd_t           rq[$];
    logic [DW-1:0] m_mem [1<<AW];
    int m_rr, m_owner, m_cnt, last_xfer, last_read;
    bit m_lock;
    int tests = 0, fails = 0, cyc = 0;

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] g;
        int i;
        g = '0;
        if (rst || hold) return g;
        if (m_lock) begin
            g[m_owner] = req[m_owner];
            return g;
        end
        for (int k = 0; k < N; k++) begin
            i = (m_rr + k) % N;
            if (req[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic bit exp_rv(output logic [IW-1:0] id, output logic [DW-1:0] d);
        id = '0;
        d  = '0;
        if (rq.size() > 0) begin
            if (rq[0].due == cyc) begin
                id = rq[0].id;
                d  = rq[0].data;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit exp_busy();
        return (last_xfer == cyc) || (last_read == cyc - 1);
    endfunction

    function automatic void model_clear();
        m_rr = 0; m_owner = 0; m_cnt = 0; m_lock = 0;
        last_xfer = -10; last_read = -10;
        rq.delete();
    endfunction

    // Apply the clock edge to the model using the inputs presented this cycle.
    task automatic advance(input logic [N-1:0] eg);
        int nxt, w;
        logic [AW-1:0] a;
        nxt = cyc + 1;
        w = 0;
        if (m_lock && (hold || !req[m_owner])) begin
            m_rr = (m_owner + 1) % N;
            m_lock = 0;
        end
        if (eg != '0) begin
            for (int k = 0; k < N; k++) if (eg[k]) w = k;
            if (!m_lock) begin
                m_owner = w; m_cnt = 1;
                if (BL > 1) m_lock = 1;
                else        m_rr = (w + 1) % N;
            end else begin
                m_cnt++;
                if (m_cnt == BL) begin
                    m_rr = (w + 1) % N;
                    m_lock = 0;
                end
            end
            a = req_addr[w*AW +: AW];
            last_xfer = nxt;
            if (req_we[w]) m_mem[a] = req_din[w*DW +: DW];
            else begin
                rq.push_back('{due: nxt + 2, id: IW'(w), data: m_mem[a]});
                last_read = nxt;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; hold = 1'b0;
`ifdef RAM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        logic [N-1:0] eg;
        rst = 1'b1; req = '1; hold = 1'b0;
        @(negedge clk);
        tests++;
        if ({ram_en, ram_we, ram_addr, ram_din, rvalid, rid, rdata, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: en=%b we=%b addr=%h din=%h rv=%b rid=%0d rdata=%h busy=%b required all 0",
                     ram_en, ram_we, ram_addr, ram_din, rvalid, rid, rdata, busy);
        end
        tests++;
        if (gnt !== '0) begin fails++; $display("FAIL reset_gnt: gnt=%b required 0000", gnt); end
        @(posedge clk); #1;
        rst = 1'b0; req = 4'b1010; model_clear(); cyc = 0;
        @(negedge clk);
        eg = model_gnt();
        tests++;
        if (gnt !== 4'b0010 || gnt !== eg) begin
            fails++; $display("FAIL reset_first_gnt: gnt=%b required 0010", gnt);
        end
        req = '0;
        advance('0);
    endtask

    task automatic test_write_read();
        logic [N-1:0] eg; logic [IW-1:0] eid; logic [DW-1:0] ed; bit ev;
        apply_reset();
        for (int s = 0; s < 6; s++) begin
            req = '0; hold = 1'b0;
            if (s == 0) begin req[0] = 1'b1; req_we[0] = 1'b1; req_addr[AW-1:0] = 4'h1; req_din[DW-1:0] = 8'hAA; end
            if (s == 1) begin req[0] = 1'b1; req_we[0] = 1'b0; end
            @(negedge clk);
            eg = model_gnt(); ev = exp_rv(eid, ed);
            tests++;
            if (gnt !== eg) begin fails++; $display("FAIL wr_gnt: cycle %0d gnt=%b required %b", cyc, gnt, eg); end
            tests++;
            if (rvalid !== ev || (ev && (rid !== eid || rdata !== ed))) begin
                fails++; $display("FAIL wr_rvalid: cycle %0d rv=%b rid=%0d rdata=%h required rv=%b rid=%0d rdata=%h", cyc, rvalid, rid, rdata, ev, eid, ed);
            end
            if (ev) void'(rq.pop_front());
            if (s == 1) begin
                tests++;
                if ({ram_en, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 4'h1, 8'hAA}) begin
                    fails++; $display("FAIL wr_cmd: en=%b we=%b addr=%h din=%h required 1 1 1 aa", ram_en, ram_we, ram_addr, ram_din);
                end
            end
            if (s == 4) begin
                tests++;
                if ({rvalid, rid, rdata} !== {1'b1, 2'd0, 8'hAA}) begin
                    fails++; $display("FAIL rd_return: rv=%b rid=%0d rdata=%h required 1 0 aa", rvalid, rid, rdata);
                end
            end
            advance(eg);
        end
    endtask

    task automatic test_burst_lock();
        logic [N-1:0] eg; logic [N-1:0] bseq [12]; logic [IW-1:0] eid; logic [DW-1:0] ed; bit ev;
        bseq = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h1, 4'h0, 4'h4};
        apply_reset();
        req_we = '0;
        req_addr = {4'h3, 4'h2, 4'h1, 4'h0};
        for (int s = 0; s < 14; s++) begin
            req = (s < 10) ? 4'b0101 : (s < 12) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            eg = model_gnt(); ev = exp_rv(eid, ed);
            if (s < 12) begin
                tests++;
                if (gnt !== bseq[s]) begin fails++; $display("FAIL burst_seq: step %0d gnt=%b required %b", s, gnt, bseq[s]); end
            end
            tests++;
            if (gnt !== eg) begin fails++; $display("FAIL burst_gnt: cycle %0d gnt=%b required %b", cyc, gnt, eg); end
            tests++;
            if (rvalid !== ev || (ev && (rid !== eid || rdata !== ed))) begin
                fails++; $display("FAIL burst_rvalid: cycle %0d rv=%b rid=%0d rdata=%h required rv=%b rid=%0d rdata=%h", cyc, rvalid, rid, rdata, ev, eid, ed);
            end
            if (ev) void'(rq.pop_front());
            advance(eg);
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] eg; logic [IW-1:0] eid; logic [DW-1:0] ed; bit ev, eb;
        apply_reset();
        req_we = '0;
        for (int s = 0; s < 10; s++) begin
            req  = (s < 8) ? 4'b0101 : 4'b0000;
            hold = (s >= 2 && s <= 5);
            @(negedge clk);
            eg = model_gnt(); ev = exp_rv(eid, ed); eb = exp_busy();
            tests++;
            if (gnt !== eg) begin fails++; $display("FAIL hold_gnt: cycle %0d gnt=%b required %b", cyc, gnt, eg); end
            tests++;
            if (rvalid !== ev || (ev && (rid !== eid || rdata !== ed))) begin
                fails++; $display("FAIL hold_rvalid: cycle %0d rv=%b rid=%0d rdata=%h required rv=%b rid=%0d rdata=%h", cyc, rvalid, rid, rdata, ev, eid, ed);
            end
            if (ev) void'(rq.pop_front());
            tests++;
            if (busy !== eb) begin fails++; $display("FAIL hold_busy: cycle %0d busy=%b required %b", cyc, busy, eb); end
            if (s == 2) begin
                tests++;
                if (gnt !== '0) begin fails++; $display("FAIL hold_block: gnt=%b required 0000", gnt); end
            end
            if (s == 4) begin
                tests++;
                if (busy !== 1'b0 || rvalid !== 1'b1) begin
                    fails++; $display("FAIL hold_drain: busy=%b rvalid=%b required busy=0 rvalid=1", busy, rvalid);
                end
            end
            if (s == 6) begin
                tests++;
                if (gnt !== 4'b0100) begin fails++; $display("FAIL hold_rotate: gnt=%b required 0100", gnt); end
            end
            advance(eg);
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] eg; logic [IW-1:0] eid; logic [DW-1:0] ed; bit ev;
        apply_reset();
        req = 4'b0010; req_we = '0; req_addr[2*AW-1:AW] = 4'h5;
        @(negedge clk);
        eg = model_gnt();
        advance(eg);
        req = '0;
        @(negedge clk);
        tests++;
        if (ram_en !== 1'b1) begin fails++; $display("FAIL rstmid_inflight: ram_en=%b required 1", ram_en); end
        rst = 1'b1;
        #1;
        tests++;
        if ({ram_en, ram_we, ram_addr, ram_din, rvalid, rid, rdata, busy, gnt} !== '0) begin
            fails++; $display("FAIL rstmid_outputs: en=%b rv=%b busy=%b addr=%h gnt=%b required all 0", ram_en, rvalid, busy, ram_addr, gnt);
        end
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0; cyc = 0;
        for (int s = 0; s < 5; s++) begin
            req = (s < 3) ? 4'b0011 : 4'b0000;
            @(negedge clk);
            eg = model_gnt(); ev = exp_rv(eid, ed);
            if (s == 0) begin
                tests++;
                if (gnt !== 4'b0001) begin fails++; $display("FAIL rstmid_first: gnt=%b required 0001", gnt); end
            end
            tests++;
            if (rvalid !== ev || (ev && (rid !== eid || rdata !== ed))) begin
                fails++; $display("FAIL rstmid_rvalid: cycle %0d rv=%b rid=%0d required rv=%b rid=%0d", cyc, rvalid, rid, ev, eid);
            end
            if (ev) void'(rq.pop_front());
            advance(eg);
        end
    endtask

`ifdef RAM_ARB_STATS_EN
    task automatic test_stats();
        logic [N-1:0] eg;
        int n;
        apply_reset();
        n = 0;
        req_we = '0;
        for (int s = 0; s < 20 && n < 5; s++) begin
            req = 4'b0010;
            @(negedge clk);
            eg = model_gnt();
            if (eg != '0) n++;
            advance(eg);
        end
        req = '0;
        @(negedge clk);
        tests++;
        if (stat_gnt_cnt[31:16] !== 16'd5 || stat_gnt_cnt[15:0] !== 16'd0) begin
            fails++; $display("FAIL stat_count: cnt1=%0d cnt0=%0d required 5 0", stat_gnt_cnt[31:16], stat_gnt_cnt[15:0]);
        end
        advance('0);
        req = 4'b0010; stat_clr = 1'b1;
        @(negedge clk);
        eg = model_gnt();
        advance(eg);
        req = '0; stat_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (eg === '0 || stat_gnt_cnt[31:16] !== 16'd0) begin
            fails++; $display("FAIL stat_clr: cnt1=%0d granted=%b required 0 with grant", stat_gnt_cnt[31:16], eg);
        end
        advance('0);
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] eg, xp; logic [IW-1:0] eid; logic [DW-1:0] ed; bit ev, eb;
        apply_reset();
        xp = '1;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || xp[i]) begin
                    req[i] = ($urandom % 3) != 0;
                    req_we[i] = $urandom % 2;
                    req_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
                    req_din[i*DW +: DW] = DW'($urandom);
                end else if ($urandom % 16 == 0) req[i] = 1'b0;
            end
            hold = ($urandom % 8) == 0;
            if (n >= 396) begin req = '0; hold = 1'b0; end
            @(negedge clk);
            eg = model_gnt(); ev = exp_rv(eid, ed); eb = exp_busy();
            tests++;
            if (gnt !== eg) begin fails++; $display("FAIL rand_gnt: cycle %0d req=%b hold=%b gnt=%b required %b", cyc, req, hold, gnt, eg); end
            tests++;
            if (rvalid !== ev || (ev && (rid !== eid || rdata !== ed))) begin
                fails++; $display("FAIL rand_rvalid: cycle %0d rv=%b rid=%0d rdata=%h required rv=%b rid=%0d rdata=%h", cyc, rvalid, rid, rdata, ev, eid, ed);
            end
            if (ev) void'(rq.pop_front());
            tests++;
            if (busy !== eb) begin fails++; $display("FAIL rand_busy: cycle %0d busy=%b required %b", cyc, busy, eb); end
            advance(eg);
            xp = eg;
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            ram_mem[a] = '0;
            m_mem[a]   = '0;
        end
        ram_dout = '0;
        model_clear();
        test_reset();
        test_write_read();
        test_burst_lock();
        test_hold();
        test_reset_mid();
`ifdef RAM_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
